mag_compare_seq: RTL and testbench

Multi-byte magnitude-compare sequencer for the calculator datapath. It takes two BYTES×8-bit operands and steps a single external 8-bit magnitude comparator (the cascaded 7485 pair) across them, one byte per clock, most significant byte first. It stops early on the first unequal byte. It drives the comparator's byte and cascade inputs, checks its three outputs, and returns a registered less/greater/equal result with a done pulse.

---
 rtl/mag_compare_seq.sv | 118 +++++++++++
 tb/tb_mag_compare_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_compare_seq.sv
// Multi-byte magnitude-compare sequencer: walks an external 8-bit comparator
// across two BYTES-wide operands MSB first, stopping on the first unequal byte.
module mag_compare_seq #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [8*BYTES-1:0]   a,
    input  logic [8*BYTES-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic                 alb,
    output logic                 agb,
    output logic                 aeb,
    output logic                 err,
    output logic [7:0]           cmp_a,
    output logic [7:0]           cmp_b,
    output logic                 cmp_ilb,
    output logic                 cmp_igb,
    output logic                 cmp_ieb,
    input  logic                 cmp_alb,
    input  logic                 cmp_agb,
    input  logic                 cmp_aeb
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_t;

    state_t                 state;
    logic [BYTES-1:0][7:0]  a_q;
    logic [BYTES-1:0][7:0]  b_q;
    logic [IDX_W-1:0]       idx;
    logic                   cmp_onehot;

    // Every step compares one byte in isolation: higher bytes were already
    // equal, so the cascade inputs always present "equal so far".
    assign cmp_ilb = 1'b0;
    assign cmp_igb = 1'b0;
    assign cmp_ieb = 1'b1;

    assign busy = (state == STEP);

    always_comb begin
        cmp_a = 8'h00;
        cmp_b = 8'h00;
        if (state == STEP) begin
            cmp_a = a_q[idx];
            cmp_b = b_q[idx];
        end
    end

    always_comb begin
        case ({cmp_alb, cmp_agb, cmp_aeb})
            3'b100, 3'b010, 3'b001: cmp_onehot = 1'b1;
            default:                cmp_onehot = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            alb   <= 1'b0;
            agb   <= 1'b0;
            aeb   <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        idx   <= IDX_TOP;
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (!cmp_onehot) begin
                        err   <= 1'b1;
                        alb   <= 1'b0;
                        agb   <= 1'b0;
                        aeb   <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cmp_alb || cmp_agb) begin
                        err   <= 1'b0;
                        alb   <= cmp_alb;
                        agb   <= cmp_agb;
                        aeb   <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (idx == '0) begin
                        err   <= 1'b0;
                        alb   <= 1'b0;
                        agb   <= 1'b0;
                        aeb   <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mag_compare_seq.sv
// Directed bench for mag_compare_seq with a behavioural 7485-style comparator
// that can be forced into a non-one-hot fault.
module tb_mag_compare_seq;

    localparam int BYTES = 4;
    localparam int W = 8 * BYTES;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy, done, alb, agb, aeb, err;
    logic [7:0]   cmp_a, cmp_b;
    logic         cmp_ilb, cmp_igb, cmp_ieb;
    logic         cmp_alb, cmp_agb, cmp_aeb;
    logic         fault;

    int tests = 0;
    int fails = 0;

    mag_compare_seq #(.BYTES(BYTES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .alb     (alb),
        .agb     (agb),
        .aeb     (aeb),
        .err     (err),
        .cmp_a   (cmp_a),
        .cmp_b   (cmp_b),
        .cmp_ilb (cmp_ilb),
        .cmp_igb (cmp_igb),
        .cmp_ieb (cmp_ieb),
        .cmp_alb (cmp_alb),
        .cmp_agb (cmp_agb),
        .cmp_aeb (cmp_aeb)
    );

    // Comparator model: on equal bytes the cascade inputs pass through.
    always_comb begin
        if (fault)
            {cmp_alb, cmp_agb, cmp_aeb} = 3'b110;
        else if (cmp_a < cmp_b)
            {cmp_alb, cmp_agb, cmp_aeb} = 3'b100;
        else if (cmp_a > cmp_b)
            {cmp_alb, cmp_agb, cmp_aeb} = 3'b010;
        else
            {cmp_alb, cmp_agb, cmp_aeb} = {cmp_ilb, cmp_igb, cmp_ieb};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   res;     // {alb, agb, aeb}
        int           cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int i);
        logic [W-1:0] s;
        s = v >> (8 * i);
        return s[7:0];
    endfunction

    // Drive start for one edge; returns 1 time unit after that edge.
    task automatic start_cmp(input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done; optionally checks the byte presented each step.
    task automatic wait_done(input logic [W-1:0] va, input logic [W-1:0] vb,
                             input bit chk_bytes, output int cycles);
        bit got;
        got = 0;
        cycles = 0;
        for (int k = 0; k < 2 * BYTES + 4; k++) begin
            @(negedge clk);
            if (chk_bytes) begin
                check("busy_step", busy, 1);
                check("cmp_a_step", cmp_a, byte_of(va, BYTES - 1 - k));
                check("cmp_b_step", cmp_b, byte_of(vb, BYTES - 1 - k));
            end
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    int cyc;

    initial begin
        vecs[0] = '{32'h3F000000, 32'h3D000000, 3'b010, 1};
        vecs[1] = '{32'h12345678, 32'h12345678, 3'b001, 4};
        vecs[2] = '{32'h0000003D, 32'h0000003F, 3'b100, 4};
        vecs[3] = '{32'h01000000, 32'h02000000, 3'b100, 1};
        vecs[4] = '{32'h00FF0000, 32'h00FE0000, 3'b010, 2};
        vecs[5] = '{32'h12345600, 32'h12345700, 3'b100, 3};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 4};
        vecs[7] = '{32'h00000000, 32'h00000000, 3'b001, 4};
        vecs[8] = '{32'h80000000, 32'h7FFFFFFF, 3'b010, 1};

        // Clock/reset
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        fault = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {alb, agb, aeb, err}, 4'b0000);
        check("rst_cmp_a", cmp_a, 8'h00);
        check("rst_cmp_b", cmp_b, 8'h00);
        check("rst_cascade", {cmp_ilb, cmp_igb, cmp_ieb}, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            start_cmp(vecs[i].a, vecs[i].b);
            check("busy_after_start", busy, 1);
            wait_done(vecs[i].a, vecs[i].b, 1, cyc);
            check("latency", cyc, vecs[i].cycles);
            check("result", {alb, agb, aeb}, vecs[i].res);
            check("err", err, 0);
            check("busy_in_done", busy, 0);
            check("idle_cmp_a", cmp_a, 8'h00);
            @(posedge clk);
            #1;
            check("done_one_cycle", done, 0);
            check("result_held", {alb, agb, aeb}, vecs[i].res);
        end

        // Busy protection, then back-to-back start in the done cycle
        start_cmp(32'h12345678, 32'h12345678);
        @(negedge clk);
        a = 32'h00000000;
        b = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done('0, '0, 0, cyc);
        check("busy_ign_latency", cyc, 3);
        check("busy_ign_result", {alb, agb, aeb, err}, 4'b0010);
        start_cmp(32'h01000000, 32'h02000000);
        check("b2b_accepted", busy, 1);
        check("b2b_result_not_cleared", {alb, agb, aeb}, 3'b001);
        wait_done(32'h01000000, 32'h02000000, 1, cyc);
        check("b2b_latency", cyc, 1);
        check("b2b_result", {alb, agb, aeb, err}, 4'b1000);

        // Reset in the middle of an equal-operand compare
        start_cmp(32'h12345678, 32'h12345678);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_res", {alb, agb, aeb, err}, 4'b0000);
        check("midrst_cmp_a", cmp_a, 8'h00);
        @(negedge clk);
        a = 32'h11111111;
        b = 32'h22222222;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_rst_ignored", busy, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("midrst_no_done", {busy, done}, 2'b00);
        end
        start_cmp(32'h00FF0000, 32'h00FE0000);
        wait_done(32'h00FF0000, 32'h00FE0000, 1, cyc);
        check("post_rst_latency", cyc, 2);
        check("post_rst_result", {alb, agb, aeb, err}, 4'b0100);

        // Comparator fault during the first step
        fault = 1'b1;
        start_cmp(32'h12345678, 32'h12345678);
        wait_done('0, '0, 0, cyc);
        fault = 1'b0;
        check("fault_latency", cyc, 1);
        check("fault_result", {alb, agb, aeb, err}, 4'b0001);
        @(posedge clk);
        #1;
        check("fault_done_pulse", done, 0);
        check("fault_err_held", err, 1);
        start_cmp(32'h3F000000, 32'h3D000000);
        wait_done(32'h3F000000, 32'h3D000000, 1, cyc);
        check("after_fault_latency", cyc, 1);
        check("after_fault_result", {alb, agb, aeb, err}, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
